muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU and the W-suffixed word variants). It sits beside the ALU in the EX stage. The pipeline starts it with a one-cycle `start` pulse and holds EX on `busy`. It consumes the forwarded operand values, i.e. the post-forwarding-mux A and B operands. It is XLEN-generic so the same block serves RV32 and RV64 builds.

## Interface
- `XLEN`, 64: operand/result width; legal values 32 and 64.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: funct3 of the M instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `word` in 1: W variant; honoured only when XLEN=64 and op ∈ {MUL, DIV, DIVU, REM, REMU}; ignored otherwise.
- `a` in XLEN: rs1 operand, captured with `start`.
- `b` in XLEN: rs2 operand, captured with `start`.
- `flush` in 1: abort the in-flight operation (branch taken / pipeline flush).
- `busy` out 1: high while in CALC; the pipeline stalls on `busy`.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out XLEN: final value; held until the next accepted `start`.

## Operation
- State machine states:
  - **IDLE**: `start & ~flush` captures `op`, `word` and the operands, then goes to CALC. A special-case division goes directly to DONE instead.
  - **CALC**: one iteration per cycle, counter from 0 to N−1. N = 32 when the W variant is honoured, else XLEN. After the last iteration, go to DONE.
  - **DONE**: `done=1`; `result` is registered; next state is IDLE.
- Multiply:
  - Radix-2 shift-add on operand magnitudes into a 2·XLEN product register.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats `a` as signed and `b` as unsigned; MULHU treats both as unsigned.
  - The product is negated at the end when the sign parities differ.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Special cases are resolved in IDLE with no CALC cycles:
  - Divide by zero: quotient = all ones, remainder = a.
  - Signed overflow (a = most-negative, b = −1): quotient = a, remainder = 0.
  - Both checks use the operand width actually selected, i.e. 32-bit when the W variant is honoured.
- W variants: operate on `a[31:0]` and `b[31:0]`; the 32-bit result is sign-extended to XLEN, including for DIVU/REMU.
- Simultaneous or edge events:
  - `start` while not IDLE is ignored; the pipeline must not issue it.
  - `flush` in CALC: go to IDLE next cycle; no `done`; `result` unchanged.
  - `flush` with `start` in IDLE: `start` is dropped.
  - `flush` in DONE: `done` still pulses, and the pipeline discards the result.
- `rst` overrides everything: state IDLE, `busy=0`, `done=0`, `result=0`, counter 0.

## Timing
- `start` is sampled at edge k.
- Normal operation: `busy` is high for cycles k+1 through k+N, and `done` is high in cycle k+N+1.
- Latency from start to `done`: 65 cycles for 64-bit ops, 33 cycles for W ops (XLEN=64), 33 cycles for XLEN=32.
- Special-case divide: `busy` never rises; `done` is high in cycle k+1.
- Earliest next `start`: the `done` cycle itself is not accepted, because state is DONE; the earliest accepted `start` is the cycle after `done`.
- `result` changes only on the edge entering DONE, or on `rst`.
- No combinational path from inputs to outputs.

## Structure
- `muldiv_pkg` holds:
  - `muldiv_op_e`: a 3-bit enum matching the funct3 encodings.
  - `muldiv_state_e`: IDLE, CALC, DONE.
  - Helper function `is_div(op)`.
- Sub-module `muldiv_step`: purely combinational single iteration.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator and quotient bit.
  - It is instantiated once in the FSM datapath.
- Everything else (operand capture, sign fix-up, counter, FSM) lives in `muldiv_unit`.

## Test plan
- MUL, a=7, b=−3 (XLEN=64) → `done` exactly 65 cycles after `start`; `result`=0xFFFF_FFFF_FFFF_FFEB; `busy` high for 64 cycles.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF → `result`=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → `result`=0.
- DIV, a=−7, b=2 → `result`=−3. REM with the same operands → `result`=−1. REMW, a=0x0000_0000_FFFF_FFF9, b=2 → `result`=0xFFFF_FFFF_FFFF_FFFF with `done` at 33 cycles.
- DIVU, b=0 → `done` next cycle; `result`=0xFFFF_FFFF_FFFF_FFFF; `busy` never high. DIV, a=0x8000_0000_0000_0000, b=−1 → `result`=a. REM with the same operands → `result`=0.
- Start a MUL, then assert `flush` on CALC cycle 10 → `busy` drops the next cycle; no `done`; `result` keeps its prior value. A new `start` two cycles later completes normally.
- Assert `rst` mid-CALC → next cycle `busy=0`, `done=0`, `result=0`. `start` pulses while `busy=1` are ignored and the in-flight result is correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and helpers shared by the multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } muldiv_state_e;
  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration; i_acc/i_opd/i_div in, o_acc/o_qbit out
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opd,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_qbit
);
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem;
  logic [XLEN+1:0] w_diff;
  always_comb begin
    w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opd} : '0);
    w_rem = i_acc[2*XLEN-1:XLEN-1];
    w_diff = {1'b0, w_rem} - {2'b0, i_opd};
    o_qbit = i_div & ~w_diff[XLEN+1];
    o_acc = i_div ? {o_qbit ? w_diff[XLEN-1:0] : w_rem[XLEN-1:0], i_acc[XLEN-2:0], 1'b0}
                  : {w_sum, i_acc[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M mul/div; i_start/i_op/i_word/i_a/i_b/i_flush in, o_busy/o_done/o_result out
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  muldiv_state_e r_state, w_state_nxt;
  muldiv_op_e r_op, w_op;
  logic r_word, r_sa, r_sb;
  logic [CW-1:0] r_cnt;
  logic [2*XLEN-1:0] r_acc, w_acc_init, w_step_acc, w_acc_nxt, w_prod;
  logic [XLEN-1:0] r_opd, r_result, w_opd_init;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_val, w_spec_res, w_q, w_r, w_dv, w_fin;
  logic w_word, w_a_sgn, w_b_sgn, w_sa, w_sb, w_b_zero, w_ovf, w_special, w_accept, w_last, w_qbit;
  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
    ext32 = {XLEN{s & v[31]}};
    ext32[31:0] = v;
  endfunction
  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc  (r_acc),
    .i_opd  (r_opd),
    .i_div  (is_div(r_op)),
    .o_acc  (w_step_acc),
    .o_qbit (w_qbit)
  );
  // MULW keeps only the low 32 product bits, which are sign-agnostic, so its operands are taken unsigned
  always_comb begin
    w_op = muldiv_op_e'(i_op);
    w_word = XLEN == 64 && i_word && (w_op == OP_MUL || is_div(w_op));
    w_a_sgn = is_div(w_op) ? ~i_op[0] : w_op != OP_MULHU && !w_word;
    w_b_sgn = is_div(w_op) ? ~i_op[0] : ~i_op[1] && !w_word;
    w_a_ext = w_word ? ext32(i_a[31:0], w_a_sgn) : i_a;
    w_b_ext = w_word ? ext32(i_b[31:0], w_b_sgn) : i_b;
    w_sa = w_a_sgn & w_a_ext[XLEN-1];
    w_sb = w_b_sgn & w_b_ext[XLEN-1];
    w_a_mag = w_sa ? -w_a_ext : w_a_ext;
    w_b_mag = w_sb ? -w_b_ext : w_b_ext;
    w_acc_init = is_div(w_op) ? {{XLEN{1'b0}}, w_word ? w_a_mag << 32 : w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
    w_opd_init = is_div(w_op) ? w_b_mag : w_a_mag;
    w_a_val = w_word ? ext32(i_a[31:0], 1'b1) : i_a;
    w_b_zero = w_word ? i_b[31:0] == '0 : i_b == '0;
    w_ovf = ~i_op[0] && (w_word ? i_a[31:0] == 32'h8000_0000 && i_b[31:0] == '1 : i_a == MIN_NEG && i_b == '1);
    w_special = is_div(w_op) && (w_b_zero || w_ovf);
    w_spec_res = w_b_zero ? (i_op[1] ? w_a_val : '1) : (i_op[1] ? '0 : w_a_val);
    w_accept = r_state == S_IDLE && i_start && !i_flush;
    w_last = r_cnt == (r_word ? CW'(31) : CW'(XLEN-1));
    w_acc_nxt = {w_step_acc[2*XLEN-1:1], w_step_acc[0] | w_qbit};
    w_prod = r_sa ^ r_sb ? -w_acc_nxt : w_acc_nxt;
    w_q = r_sa ^ r_sb ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    w_r = r_sa ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    w_dv = r_op[1] ? w_r : w_q;
    // after 32 shift-right steps the 32x32 product sits in the middle of the accumulator
    w_fin = is_div(r_op) ? (r_word ? ext32(w_dv[31:0], 1'b1) : w_dv)
          : r_word ? ext32(w_acc_nxt[XLEN-1 -: 32], 1'b1)
          : r_op == OP_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_special) w_state_nxt = S_DONE;
              else if (w_accept) w_state_nxt = S_CALC;
      S_CALC: if (i_flush) w_state_nxt = S_IDLE;
              else if (w_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= OP_MUL;
      r_word <= 1'b0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_opd <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op <= w_op;
      r_word <= w_word;
      r_sa <= w_sa;
      r_sb <= w_sb;
      r_cnt <= '0;
      r_acc <= w_acc_init;
      r_opd <= w_opd_init;
      if (w_special) r_result <= w_spec_res;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last && !i_flush) r_result <= w_fin;
    end
  end
  assign o_busy = r_state == S_CALC;
  assign o_done = r_state == S_DONE;
  assign o_result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst, start, word, flush;
  logic [2:0] op;
  logic [63:0] a, b;
  logic busy, done;
  logic [63:0] result;
  int n_total = 0;
  int n_bad = 0;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  muldiv_unit #(.XLEN(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (start),
    .i_op     (op),
    .i_word   (word),
    .i_a      (a),
    .i_b      (b),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] pa, pb, p;
    longint sx, sy;
    longint unsigned ux, uy;
    int sx32, sy32;
    int unsigned ux32, uy32;
    logic [31:0] r32;
    logic [63:0] r;
    sx = x; sy = y; ux = x; uy = y;
    sx32 = x[31:0]; sy32 = y[31:0]; ux32 = x[31:0]; uy32 = y[31:0];
    r32 = '0;
    r = '0;
    if (w && (o == 3'd0 || o[2])) begin
      case (o)
        3'd0: r32 = x[31:0] * y[31:0];
        3'd4: if (uy32 == 0) r32 = '1; else if (x[31:0] == 32'h8000_0000 && y[31:0] == '1) r32 = x[31:0]; else r32 = sx32 / sy32;
        3'd5: if (uy32 == 0) r32 = '1; else r32 = ux32 / uy32;
        3'd6: if (uy32 == 0) r32 = x[31:0]; else if (x[31:0] == 32'h8000_0000 && y[31:0] == '1) r32 = '0; else r32 = sx32 % sy32;
        3'd7: if (uy32 == 0) r32 = ux32; else r32 = ux32 % uy32;
        default: r32 = '0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    pa = {{64{x[63]}}, x};
    pb = {{64{y[63]}}, y};
    if (o == 3'd2 || o == 3'd3) pb = {64'd0, y};
    if (o == 3'd3) pa = {64'd0, x};
    p = pa * pb;
    case (o)
      3'd0: r = p[63:0];
      3'd1, 3'd2, 3'd3: r = p[127:64];
      3'd4: if (uy == 0) r = '1; else if (x == MIN64 && y == ONES) r = x; else r = sx / sy;
      3'd5: if (uy == 0) r = '1; else r = ux / uy;
      3'd6: if (uy == 0) r = x; else if (x == MIN64 && y == ONES) r = '0; else r = sx % sy;
      default: if (uy == 0) r = x; else r = ux % uy;
    endcase
    return r;
  endfunction
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] res, output int lat, output int nb);
    @(negedge clk);
    start = 1'b1; op = o; word = w; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nb = 0;
    while (!done && lat < 200) begin
      nb += int'(busy);
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    res = result;
  endtask
  initial begin
    logic [63:0] res;
    int lat, nb, j;
    rst = 1'b1; start = 1'b0; word = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    rst = 1'b0;
    run_op(3'd0, 1'b0, 64'd7, -64'sd3, res, lat, nb);
    chk("mul_res", res, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_lat", 64'(lat), 64'd65);
    chk("mul_busy", 64'(nb), 64'd64);
    run_op(3'd3, 1'b0, ONES, ONES, res, lat, nb);
    chk("mulhu_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd1, 1'b0, ONES, ONES, res, lat, nb);
    chk("mulh_res", res, 64'd0);
    run_op(3'd4, 1'b0, -64'sd7, 64'd2, res, lat, nb);
    chk("div_res", res, -64'sd3);
    run_op(3'd6, 1'b0, -64'sd7, 64'd2, res, lat, nb);
    chk("rem_res", res, -64'sd1);
    run_op(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, res, lat, nb);
    chk("remw_res", res, ONES);
    chk("remw_lat", 64'(lat), 64'd33);
    run_op(3'd5, 1'b0, 64'd1234, 64'd0, res, lat, nb);
    chk("divu0_res", res, ONES);
    chk("divu0_lat", 64'(lat), 64'd1);
    chk("divu0_busy", 64'(nb), 64'd0);
    run_op(3'd4, 1'b0, MIN64, ONES, res, lat, nb);
    chk("divovf_res", res, MIN64);
    run_op(3'd6, 1'b0, MIN64, ONES, res, lat, nb);
    chk("removf_res", res, 64'd0);
    run_op(3'd0, 1'b0, 64'd5, 64'd6, res, lat, nb);
    chk("mul30_res", res, 64'd30);
    @(negedge clk);
    start = 1'b1; op = 3'd0; word = 1'b0; a = 64'd123; b = 64'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_result", result, 64'd30);
    @(negedge clk);
    chk("flush_done2", 64'(done), 64'd0);
    run_op(3'd0, 1'b0, 64'd123, 64'd456, res, lat, nb);
    chk("post_flush_res", res, 64'd56088);
    chk("post_flush_lat", 64'(lat), 64'd65);
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd5; a = 64'd9; b = 64'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("startflush_busy", 64'(busy), 64'd0);
    chk("startflush_done", 64'(done), 64'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd5; word = 1'b0; a = 64'd100; b = 64'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", result, 64'd0);
    run_op(3'd5, 1'b0, 64'd100, 64'd3, res, lat, nb);
    chk("post_rst_res", res, 64'd33);
    @(negedge clk);
    start = 1'b1; op = 3'd4; word = 1'b0; a = 64'd1000; b = 64'd7;
    @(negedge clk);
    start = 1'b0;
    j = 1;
    while (!done && j < 200) begin
      start = busy && (j % 10 == 5);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op = 3'($urandom_range(0, 7));
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    if (!done) chk("ign_timeout", 64'd0, 64'd1);
    chk("ign_res", result, 64'd142);
    chk("ign_lat", 64'(j), 64'd65);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] ro;
      logic rw, hon, bz, ov;
      logic [63:0] ra, rb;
      int m, t, exp_lat;
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      m = $urandom_range(0, 4);
      if (m == 1) rb = rw ? {$urandom, 32'd0} : 64'd0;
      if (m == 2) begin
        ra = rw ? {$urandom, 32'h8000_0000} : MIN64;
        rb = rw ? {$urandom, 32'hFFFF_FFFF} : ONES;
      end
      if (m == 3) begin
        t = $urandom_range(0, 200) - 100;
        ra = 64'(longint'(t));
        t = $urandom_range(0, 20) - 10;
        rb = 64'(longint'(t));
      end
      hon = rw && (ro == 3'd0 || ro[2]);
      bz = hon ? rb[31:0] == 32'd0 : rb == 64'd0;
      ov = !ro[0] && (hon ? (ra[31:0] == 32'h8000_0000 && rb[31:0] == 32'hFFFF_FFFF) : (ra == MIN64 && rb == ONES));
      exp_lat = (ro[2] && (bz || ov)) ? 1 : hon ? 33 : 65;
      run_op(ro, rw, ra, rb, res, lat, nb);
      chk($sformatf("rnd%0d_op%0d_w%0d_res", i, ro, rw), res, ref_model(ro, rw, ra, rb));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat));
      chk($sformatf("rnd%0d_busy", i), 64'(nb), 64'(exp_lat - 1));
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
